// File: rtl/board_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : board_scanner_if
// Description : Read bus between the board scanner and the board RAM.
//               The RAM registers the address once, so q/state follow the
//               address by one clock edge.
//   addr_macro  4  macro (sub-board) address, 1..9
//   addr_micro  4  micro (cell) address, 1..9
//   q           2  cell data of the registered address
//   state       2  macro result of the registered macro address
// Revision    : 1.0 - initial release
// ============================================================================
interface board_scanner_if;
    logic [3:0] addr_macro;
    logic [3:0] addr_micro;
    logic [1:0] q;
    logic [1:0] state;

    modport master (
        output addr_macro,
        output addr_micro,
        input  q,
        input  state
    );

    modport slave (
        input  addr_macro,
        input  addr_micro,
        output q,
        output state
    );
endinterface
`default_nettype wire

// File: rtl/board_scanner.sv
`default_nettype none
// ============================================================================
// Module      : board_scanner
// Description : Read-side master for the board RAM. On iniciar it sweeps the
//               RAM addresses over the playable cells, captures cell values
//               and macro results, streams cells to the display path and
//               finally resolves the global ultimate-tic-tac-toe winner.
// Ports       : clk, clear (sync active-high reset), iniciar (start pulse)
//               ram          RAM read bus (addresses out, q/state in)
//               cell_*       captured-cell stream (cell_valid strobe)
//               macro_states 2 bits per macro, macro m at [2m-1:2m-2]
//               vencedor     global result (00 run, 01 P1, 10 P2, 11 draw)
//               ocupado      scan in progress
//               pronto       one-cycle pulse: results are final
// Config      : BOARD_SCAN_CELL_STREAM_EN - full 81-cell sweep with cell
//               stream. Undefined: only (m,1) is read, cell_* tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module board_scanner (
    input  wire logic          clk,
    input  wire logic          clear,
    input  wire logic          iniciar,
    board_scanner_if.master    ram,
    output logic               cell_valid,
    output logic [3:0]         cell_macro,
    output logic [3:0]         cell_micro,
    output logic [1:0]         cell_data,
    output logic [17:0]        macro_states,
    output logic [1:0]         vencedor,
    output logic               ocupado,
    output logic               pronto
);

`ifdef BOARD_SCAN_CELL_STREAM_EN
    localparam logic [3:0] c_last_micro = 4'd9;
`else
    localparam logic [3:0] c_last_micro = 4'd1;
`endif

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        VARRE  = 2'd1,
        ESCOAR = 2'd2,
        FINAL  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  addr_macro_q, addr_macro_d;
    logic [3:0]  addr_micro_q, addr_micro_d;
    // Stage 0 tracks the address register, stage 1 the RAM's own address
    // register; the cell data matching stage 1 is on q.
    logic        s0_vld_q, s0_vld_d;
    logic [3:0]  s0_mac_q, s0_mac_d;
    logic [3:0]  s0_mic_q, s0_mic_d;
    logic        s1_vld_q, s1_vld_d;
    logic [3:0]  s1_mac_q, s1_mac_d;
    logic [3:0]  s1_mic_q, s1_mic_d;
    logic [17:0] macro_states_q, macro_states_d;
    logic [1:0]  vencedor_q, vencedor_d;
    logic        ocupado_q, ocupado_d;
    logic        pronto_q, pronto_d;

    logic [3:0]  w_next_macro;
    logic [3:0]  w_next_micro;
    logic        w_last_issue;
    logic        w_last_capture;
    logic        w_slot_done;
    logic [1:0]  w_winner;

    // True when any of the 8 board lines holds three results equal to p.
    function automatic logic f_has_line(input logic [17:0] ms, input logic [1:0] p);
        logic [8:0] hit;
        for (int i = 0; i < 9; i++) begin
            hit[i] = (ms[2*i +: 2] == p);
        end
        return (hit[0] & hit[1] & hit[2]) | (hit[3] & hit[4] & hit[5]) |
               (hit[6] & hit[7] & hit[8]) | (hit[0] & hit[3] & hit[6]) |
               (hit[1] & hit[4] & hit[7]) | (hit[2] & hit[5] & hit[8]) |
               (hit[0] & hit[4] & hit[8]) | (hit[2] & hit[4] & hit[6]);
    endfunction

    function automatic logic [1:0] f_winner(input logic [17:0] ms);
        logic full;
        full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (ms[2*i +: 2] == 2'b00) begin
                full = 1'b0;
            end
        end
        // Draw macros (11) never match 01 or 10, so they block lines.
        if (f_has_line(ms, 2'b01)) begin
            return 2'b01;
        end else if (f_has_line(ms, 2'b10)) begin
            return 2'b10;
        end else if (full) begin
            return 2'b11;
        end
        return 2'b00;
    endfunction

    // Address sequencing
    always_comb begin
`ifdef BOARD_SCAN_CELL_STREAM_EN
        if (addr_micro_q == 4'd9) begin
            w_next_macro = addr_macro_q + 4'd1;
            w_next_micro = 4'd1;
        end else begin
            w_next_macro = addr_macro_q;
            w_next_micro = addr_micro_q + 4'd1;
        end
`else
        w_next_macro = addr_macro_q + 4'd1;
        w_next_micro = 4'd1;
`endif
        w_last_issue   = (w_next_macro == 4'd9) && (w_next_micro == c_last_micro);
        w_last_capture = s1_vld_q && (s1_mac_q == 4'd9) && (s1_mic_q == c_last_micro);
        // The macro result is taken with the last micro of each macro; with
        // only micro 1 issued this is every capture.
        w_slot_done    = s1_vld_q && (s1_mic_q == c_last_micro);
        w_winner       = f_winner(macro_states_q);
    end

    // Next-state and datapath
    always_comb begin
        state_d        = state_q;
        addr_macro_d   = addr_macro_q;
        addr_micro_d   = addr_micro_q;
        s0_vld_d       = 1'b0;
        s0_mac_d       = s0_mac_q;
        s0_mic_d       = s0_mic_q;
        s1_vld_d       = s0_vld_q;
        s1_mac_d       = s0_mac_q;
        s1_mic_d       = s0_mic_q;
        macro_states_d = macro_states_q;
        vencedor_d     = vencedor_q;
        ocupado_d      = ocupado_q;
        pronto_d       = 1'b0;

        case (state_q)
            OCIOSO: begin
                if (iniciar) begin
                    state_d        = VARRE;
                    addr_macro_d   = 4'd1;
                    addr_micro_d   = 4'd1;
                    s0_vld_d       = 1'b1;
                    s0_mac_d       = 4'd1;
                    s0_mic_d       = 4'd1;
                    macro_states_d = 18'd0;
                    ocupado_d      = 1'b1;
                end
            end
            VARRE: begin
                addr_macro_d = w_next_macro;
                addr_micro_d = w_next_micro;
                s0_vld_d     = 1'b1;
                s0_mac_d     = w_next_macro;
                s0_mic_d     = w_next_micro;
                if (w_last_issue) begin
                    state_d = ESCOAR;
                end
            end
            ESCOAR: begin
                if (w_last_capture) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                vencedor_d = w_winner;
                pronto_d   = 1'b1;
                ocupado_d  = 1'b0;
                state_d    = OCIOSO;
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase

        if (w_slot_done) begin
            for (int m = 1; m <= 9; m++) begin
                if (s1_mac_q == 4'(m)) begin
                    macro_states_d[2*m-2 +: 2] = ram.state;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q        <= OCIOSO;
            addr_macro_q   <= 4'd0;
            addr_micro_q   <= 4'd0;
            s0_vld_q       <= 1'b0;
            s0_mac_q       <= 4'd0;
            s0_mic_q       <= 4'd0;
            s1_vld_q       <= 1'b0;
            s1_mac_q       <= 4'd0;
            s1_mic_q       <= 4'd0;
            macro_states_q <= 18'd0;
            vencedor_q     <= 2'b00;
            ocupado_q      <= 1'b0;
            pronto_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_macro_q   <= addr_macro_d;
            addr_micro_q   <= addr_micro_d;
            s0_vld_q       <= s0_vld_d;
            s0_mac_q       <= s0_mac_d;
            s0_mic_q       <= s0_mic_d;
            s1_vld_q       <= s1_vld_d;
            s1_mac_q       <= s1_mac_d;
            s1_mic_q       <= s1_mic_d;
            macro_states_q <= macro_states_d;
            vencedor_q     <= vencedor_d;
            ocupado_q      <= ocupado_d;
            pronto_q       <= pronto_d;
        end
    end

`ifdef BOARD_SCAN_CELL_STREAM_EN
    logic       cell_valid_q, cell_valid_d;
    logic [3:0] cell_macro_q, cell_macro_d;
    logic [3:0] cell_micro_q, cell_micro_d;
    logic [1:0] cell_data_q, cell_data_d;

    // Capture registers hold the last cell; only the strobe is one cycle.
    always_comb begin
        cell_valid_d = s1_vld_q;
        cell_macro_d = cell_macro_q;
        cell_micro_d = cell_micro_q;
        cell_data_d  = cell_data_q;
        if (s1_vld_q) begin
            cell_macro_d = s1_mac_q;
            cell_micro_d = s1_mic_q;
            cell_data_d  = ram.q;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cell_valid_q <= 1'b0;
            cell_macro_q <= 4'd0;
            cell_micro_q <= 4'd0;
            cell_data_q  <= 2'b00;
        end else begin
            cell_valid_q <= cell_valid_d;
            cell_macro_q <= cell_macro_d;
            cell_micro_q <= cell_micro_d;
            cell_data_q  <= cell_data_d;
        end
    end

    assign cell_valid = cell_valid_q;
    assign cell_macro = cell_macro_q;
    assign cell_micro = cell_micro_q;
    assign cell_data  = cell_data_q;
`else
    logic w_unused_q;
    assign w_unused_q = ^ram.q;

    assign cell_valid = 1'b0;
    assign cell_macro = 4'd0;
    assign cell_micro = 4'd0;
    assign cell_data  = 2'b00;
`endif

    assign ram.addr_macro = addr_macro_q;
    assign ram.addr_micro = addr_micro_q;
    assign macro_states   = macro_states_q;
    assign vencedor       = vencedor_q;
    assign ocupado        = ocupado_q;
    assign pronto         = pronto_q;

endmodule
`default_nettype wire

// File: doc/board_scanner.md
# board_scanner

Read-side master for the board RAM. On `iniciar` it sweeps the board RAM's address inputs across every playable cell, captures each cell value (`q`) and each macro cell's result (`state`), and streams the cells to the display path. It then computes the global ultimate-tic-tac-toe winner from the nine macro results. It sits between the game controller and the board RAM; the top level gives it the RAM address bus while `ocupado` is high and holds `we` low during that time.

## Interface
Parameters: none.
- `clk`  in  1  system clock; all logic on rising edge
- `clear`  in  1  reset, synchronous, active-high
- `iniciar`  in  1  start pulse; sampled only in OCIOSO
- `q`  in  2  board RAM cell data (00 empty, 01 player 1, 10 player 2)
- `state`  in  2  board RAM macro result (00 running, 01 P1, 10 P2, 11 draw)
- `addr_macro`  out  4  registered RAM macro address, 1..9
- `addr_micro`  out  4  registered RAM micro address, 1..9
- `cell_valid`  out  1  one-cycle strobe: `cell_*` outputs hold a captured cell
- `cell_macro`, `cell_micro`  out  4 each  address of the captured cell
- `cell_data`  out  2  captured `q`
- `macro_states`  out  18  result of macro m in bits [2m-1:2m-2], m=1..9
- `vencedor`  out  2  global result, same encoding as `state`
- `ocupado`  out  1  scan in progress
- `pronto`  out  1  one-cycle pulse: `macro_states` and `vencedor` are final

## Operation
- FSM states: OCIOSO → VARRE → ESCOAR → FINAL → OCIOSO.
- OCIOSO: `ocupado`=0. `iniciar`=1 → VARRE. At that edge: `addr_macro`=1, `addr_micro`=1, `ocupado`=1, and `macro_states` cleared to 0.
- VARRE: one new address per cycle.
  - Micro address runs 1..9; it then wraps to 1 and the macro address increments.
  - After (9,9) is issued → ESCOAR. Addresses hold at (9,9).
- The board RAM has 1-cycle address registration, so read data for an address comes back after a 2-edge pipeline.
  - A 2-deep shift register carries {valid, macro, micro} alongside the request.
  - At capture: `cell_data`←`q`, `cell_valid`←1.
  - When the captured micro is 9, `state` is written into the `macro_states` slot for that macro.
- ESCOAR: waits until the last capture → FINAL.
- FINAL: computes `vencedor` from `macro_states` over the 8 lines (rows 1-2-3 / 4-5-6 / 7-8-9, columns 1-4-7 / 2-5-8 / 3-6-9, diagonals 1-5-9 / 3-5-7):
  - A line of three 01 gives 01; a line of three 10 gives 10.
  - A macro with 11 (draw) counts for no player.
  - If there is no line and all nine macros are nonzero → 11.
  - Otherwise → 00.
  - At the FINAL edge: `pronto`=1 for one cycle, `ocupado`=0, then OCIOSO.
- `iniciar` while `ocupado` is ignored. `iniciar` in the FINAL cycle is also ignored.
- `vencedor` and `macro_states` hold until the next start (`macro_states`) or the next FINAL (`vencedor`).
- Writes to the RAM during a scan are a system error. The scan result then reflects mixed contents and is not checked.

## Timing
- Reset: `addr_macro`=`addr_micro`=0, `cell_*`=0, `cell_valid`=0, `macro_states`=0, `vencedor`=00, `ocupado`=0, `pronto`=0, FSM=OCIOSO, pipeline valid bits cleared.
- Let E0 be the edge that samples `iniciar`.
- Address index i (0..80) is driven after edge E0+i.
- Cell i is captured at edge E0+i+2, with `cell_valid` high for the following cycle.
- The macro m result is captured with cell index 9m-1.
- Last capture at E0+82. `vencedor` is registered and `pronto` is high after E0+83. `ocupado` is high after E0 through E0+82 and low after E0+83.
- `clear` mid-scan: at that edge, full reset as above. No `pronto` is produced and partial `macro_states` are discarded.
- `clear` and `iniciar` in the same cycle: `clear` wins.

## Configuration
- `BOARD_SCAN_CELL_STREAM_EN` defined: behaviour as above, with an 81-address sweep and 84-cycle scan.
- Not defined:
  - Micro address is fixed at 1; only (m,1), m=1..9, is issued.
  - `cell_valid`, `cell_macro`, `cell_micro`, `cell_data` are tied to 0.
  - `state` is captured for every issued address.
  - Last capture at E0+10, `pronto` after E0+11.
  - The pipeline and FSM are otherwise identical.

## Test plan
- Empty board, start → 81 `cell_valid` strobes, all `cell_data`=00, addresses in order (1,1)…(9,9), `macro_states`=0, `vencedor`=00, `pronto` exactly 84 cycles after the `iniciar` edge.
- Macros 1, 5, 9 won by P1 (cells 1-2-3 = 01), others empty → `macro_states` slots 1, 5, 9 = 01, `vencedor`=01.
- Macros 3, 5, 7 won by P2 and macro 1 drawn (11) → `vencedor`=10, slot 1 = 11.
- All nine macros decided, with draws breaking every line → `vencedor`=11.
- `clear` asserted at E0+40 → all outputs at reset values next cycle, no `pronto`. A new `iniciar` then completes normally. `iniciar` pulsed at E0+20 → no effect on the sequence.
- With the macro undefined: P1 wins macro 2 → 9 addresses (m,1), `cell_valid` never high, slot 2 = 01, `pronto` 12 cycles after the `iniciar` edge.
